// File: rtl/mainfsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Latency: Moore outputs from the state register (ImmSrc combinational from Op); load 5, store/DP 4, branch/undefined 3 cycles.
// Backpressure: none; advances one state per clock, reset aborts the current instruction back to FETCH.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [1:0] ImmSrc,
    output logic       Retire,
    output logic [3:0] State
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] UNKNOWN  = 4'd10;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // Only I (bit 5) and L (bit 0) steer the sequence; the rest belong to the ALU decoder.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // State register; reset lands in FETCH on the first clock edge it is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; Op/Funct only matter in DECODE and MEMADR.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWR:    state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            UNKNOWN:  state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Moore output decode; reset shows FETCH selects but suppresses every enable.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        Retire    = 1'b0;
        if (reset) begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
        end else begin
            case (state_q)
                FETCH: begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                MEMADR: begin
                    ALUSrcB   = 2'b01;
                end
                MEMRD: begin
                    AdrSrc    = 1'b1;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                    Retire    = 1'b1;
                end
                MEMWR: begin
                    AdrSrc    = 1'b1;
                    MemW      = 1'b1;
                    Retire    = 1'b1;
                end
                EXECUTER: begin
                    ALUOp     = 1'b1;
                end
                EXECUTEI: begin
                    ALUSrcB   = 2'b01;
                    ALUOp     = 1'b1;
                end
                ALUWB: begin
                    RegW      = 1'b1;
                    Retire    = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                    Retire    = 1'b1;
                end
                default: begin
                    // UNKNOWN and unused codes drive nothing.
                end
            endcase
        end
    end

    // Immediate format follows the instruction class directly.
    always_comb begin
        case (Op)
            2'b01:   ImmSrc = 2'b01;
            2'b10:   ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign State = state_q;

endmodule
